// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bus bundle for the instruction fetch stage. It carries the
//                program ROM read port, the decode handshake and the
//                redirect/halt controls from the core.
//                master : the fetch unit
//                slave  : ROM + decode/execute core side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               rom_en;       // ROM read strobe
    logic [ADDR_W-1:0]  rom_addr;     // ROM read address
    logic [INSTR_W-1:0] rom_data;     // ROM word, one cycle after rom_en
    logic               instr_valid;  // head of prefetch buffer is valid
    logic               instr_ready;  // decode accepts head this cycle
    logic [INSTR_W-1:0] instr;        // head instruction
    logic [ADDR_W-1:0]  instr_pc;     // address of head instruction
    logic               redirect;     // flush and restart at redirect_pc
    logic [ADDR_W-1:0]  redirect_pc;  // new fetch address
    logic               halt;         // level, inhibits new ROM reads
    logic               fetch_idle;   // halted, empty, nothing in flight

    modport master (
        output rom_en, rom_addr,
        input  rom_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect, redirect_pc, halt,
        output fetch_idle
    );

    modport slave (
        input  rom_en, rom_addr,
        output rom_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect, redirect_pc, halt,
        input  fetch_idle
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the fetch PC, issues ROM reads
//                (1-cycle latency) and keeps a 2-entry prefetch FIFO whose
//                head is presented to decode over valid/ready. Redirects
//                flush the FIFO and kill the read in flight; halt stops new
//                reads while the pipeline drains.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous, active-high
//                bus   - fetch_unit_if.master (ROM port, decode handshake,
//                        redirect/halt controls, fetch_idle status)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fetch_unit_if.master bus
);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [1:0]         r_count;
    logic [INSTR_W-1:0] r_buf_instr [2];
    logic [ADDR_W-1:0]  r_buf_pc    [2];

    logic               w_pop;
    logic               w_push;
    logic [2:0]         w_occupancy;
    logic               w_issue;

    // Head is always entry 0; it is registered, so instr_valid has no
    // combinational dependence on instr_ready.
    assign w_pop  = (r_count != 2'd0) && bus.instr_ready;
    // Whatever was issued last cycle lands now; a kill clears r_inflight.
    assign w_push = r_inflight;

    // Slots that will be committed after this edge, before any new issue.
    // pop implies count >= 1, so this never underflows.
    assign w_occupancy = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue     = !reset && !bus.halt && !bus.redirect &&
                         (w_occupancy < 3'd2);

    assign bus.rom_en      = w_issue;
    assign bus.rom_addr    = r_fetch_pc;
    assign bus.instr_valid = (r_count != 2'd0);
    assign bus.instr       = r_buf_instr[0];
    assign bus.instr_pc    = r_buf_pc[0];
    assign bus.fetch_idle  = bus.halt && (r_count == 2'd0) && !r_inflight;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc     <= RESET_PC;
            r_inflight     <= 1'b0;
            r_inflight_pc  <= '0;
            r_count        <= 2'd0;
            r_buf_instr[0] <= '0;
            r_buf_instr[1] <= '0;
            r_buf_pc[0]    <= '0;
            r_buf_pc[1]    <= '0;
        end else begin
            assert (!(w_push && !w_pop && r_count == 2'd2));

            // Redirect forces w_issue low, so this also kills the read in flight.
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end

            if (bus.redirect) begin
                // Entries are flushed by count only; entry 0 keeps the last
                // presented word so instr/instr_pc hold while invalid.
                r_fetch_pc <= bus.redirect_pc;
                r_count    <= 2'd0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                end

                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_buf_instr[0] <= bus.rom_data;
                            r_buf_pc[0]    <= r_inflight_pc;
                        end else begin
                            r_buf_instr[1] <= bus.rom_data;
                            r_buf_pc[1]    <= r_inflight_pc;
                        end
                        r_count <= r_count + 2'd1;
                    end
                    2'b01: begin
                        // With a single entry the head is left untouched so
                        // the outputs hold their last value.
                        if (r_count == 2'd2) begin
                            r_buf_instr[0] <= r_buf_instr[1];
                            r_buf_pc[0]    <= r_buf_pc[1];
                        end
                        r_count <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd2) begin
                            r_buf_instr[0] <= r_buf_instr[1];
                            r_buf_pc[0]    <= r_buf_pc[1];
                            r_buf_instr[1] <= bus.rom_data;
                            r_buf_pc[1]    <= r_inflight_pc;
                        end else begin
                            r_buf_instr[0] <= bus.rom_data;
                            r_buf_pc[0]    <= r_inflight_pc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A queue-based model of
//                the fetch stage predicts every output each cycle; directed
//                scenarios add explicit sequence/latency checks, followed by
//                a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    localparam int         ADDR_W   = 8;
    localparam int         INSTR_W  = 16;
    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] rom [256];

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency; garbage when not strobed.
    always @(posedge clk)
        bus.rom_data <= bus.rom_en ? rom[bus.rom_addr] : 16'($urandom);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    entry_t     q[$];
    entry_t     held;
    logic [7:0] m_fetch_pc;
    bit         m_inflight;
    logic [7:0] m_inflight_pc;

    // Observation logs
    logic [7:0] acc_pc[$];
    int         acc_cyc[$];
    logic [7:0] last_issued;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] acc_at(input int i);
        return (i < acc_pc.size()) ? acc_pc[i] : 8'hxx;
    endfunction

    function automatic int acc_cyc_at(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
    endfunction

    task automatic model_reset();
        q.delete();
        held          = '0;
        m_fetch_pc    = RESET_PC;
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, advance the
    // model with the same inputs the DUT sees at the next rising edge.
    task automatic step();
        int     n;
        bit     pop;
        bit     en;
        entry_t disp;
        @(negedge clk);
        n    = q.size();
        pop  = (n > 0) && bus.instr_ready;
        en   = !reset && !bus.halt && !bus.redirect &&
               ((n + int'(m_inflight) - int'(pop)) < 2);
        disp = (n > 0) ? q[0] : held;

        check("instr_valid", bus.instr_valid, n > 0);
        check("instr",       bus.instr,       disp.instr);
        check("instr_pc",    bus.instr_pc,    disp.pc);
        check("rom_en",      bus.rom_en,      en);
        if (en) check("rom_addr", bus.rom_addr, m_fetch_pc);
        check("fetch_idle",  bus.fetch_idle,  bus.halt && n == 0 && !m_inflight);

        if (bus.instr_valid && bus.instr_ready) begin
            acc_pc.push_back(bus.instr_pc);
            acc_cyc.push_back(cyc);
        end
        if (bus.rom_en) last_issued = bus.rom_addr;

        if (reset) begin
            model_reset();
        end else begin
            held = disp;
            if (pop) void'(q.pop_front());
            if (bus.redirect) begin
                q.delete();
                m_fetch_pc = bus.redirect_pc;
                m_inflight = 1'b0;
            end else begin
                if (m_inflight) q.push_back('{instr: rom[m_inflight_pc], pc: m_inflight_pc});
                if (en) begin
                    m_inflight_pc = m_fetch_pc;
                    m_fetch_pc    = m_fetch_pc + 8'd1;
                end
                m_inflight = en;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_pc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int         rel;
        logic [7:0] prev;
        logic [7:0] nxt;

        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        foreach (rom[i]) rom[i] = 16'($urandom);
        rom[0] = 16'h1005;
        rom[1] = 16'h2003;
        rom[2] = 16'h3001;
        rom[3] = 16'hF000;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();                               // reset state

        // 1: release from reset, streaming
        reset = 1'b0; bus.instr_ready = 1'b1; clear_log(); rel = cyc;
        repeat (6) step();
        check("t1_count", acc_pc.size(), 4);
        check("t1_first_latency", acc_cyc_at(0) - rel, 2);
        check("t1_consecutive", acc_cyc_at(3) - acc_cyc_at(0), 3);
        for (int i = 0; i < 4; i++) check("t1_pc", acc_at(i), 8'(i));

        // 2: decode stalls after first valid, then drains in order
        reset = 1'b1; step();
        reset = 1'b0; bus.instr_ready = 1'b0;
        repeat (8) step();
        check("t2_head_valid", bus.instr_valid, 1'b1);
        check("t2_head_pc", bus.instr_pc, 8'h00);
        check("t2_rom_en_low", bus.rom_en, 1'b0);
        bus.instr_ready = 1'b1; clear_log();
        repeat (3) step();
        check("t2_count", acc_pc.size(), 3);
        for (int i = 0; i < 3; i++) check("t2_pc", acc_at(i), 8'(i));

        // 3: redirect while the read of 03 is in flight
        reset = 1'b1; step();
        reset = 1'b0; bus.instr_ready = 1'b1; clear_log();
        repeat (4) step();
        bus.redirect = 1'b1; bus.redirect_pc = 8'h40; rel = cyc;
        step();
        bus.redirect = 1'b0;
        repeat (5) step();
        check("t3_count", acc_pc.size(), 6);
        check("t3_pc0", acc_at(0), 8'h00);
        check("t3_pc1", acc_at(1), 8'h01);
        check("t3_pc2", acc_at(2), 8'h02);
        check("t3_pc3", acc_at(3), 8'h40);
        check("t3_pc4", acc_at(4), 8'h41);
        check("t3_redirect_latency", acc_cyc_at(3) - rel, 3);

        // 4: redirect near the top of the address space, PC wraps
        bus.redirect = 1'b1; bus.redirect_pc = 8'hFE;
        step();
        bus.redirect = 1'b0; clear_log();
        repeat (6) step();
        check("t4_pc0", acc_at(0), 8'hFE);
        check("t4_pc1", acc_at(1), 8'hFF);
        check("t4_pc2", acc_at(2), 8'h00);
        check("t4_pc3", acc_at(3), 8'h01);

        // 5: halt while streaming, drain, then resume without skip/repeat
        bus.halt = 1'b1;
        step();
        prev = last_issued;
        repeat (4) step();
        check("t5_idle", bus.fetch_idle, 1'b1);
        check("t5_drained", bus.instr_valid, 1'b0);
        check("t5_no_issue", last_issued, prev);
        bus.halt = 1'b0;
        step();
        nxt = prev + 8'd1;
        check("t5_resume_addr", last_issued, nxt);

        // 6: reset with a full buffer
        bus.instr_ready = 1'b0;
        repeat (4) step();
        reset = 1'b1; step();
        reset = 1'b0;
        check("t6_valid_cleared", bus.instr_valid, 1'b0);
        bus.instr_ready = 1'b1; clear_log();
        repeat (5) step();
        check("t6_restart_pc", acc_at(0), RESET_PC);
        check("t6_second_pc", acc_at(1), RESET_PC + 8'd1);

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            bus.instr_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 8) bus.halt = ~bus.halt;
            bus.redirect    = ($urandom_range(0, 99) < 6);
            bus.redirect_pc = 8'($urandom);
            reset           = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
